multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder. An FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath strobes (IR/PC load, ALU op, register write, immediate select, jump), plus a req/ack handshake to a shared instruction/data memory. It sits between the instruction register and the datapath; the opcode comes from IR bits.

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/op_decode.sv | 44 ++++
 rtl/multicycle_control.sv | 136 +++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller:
// FSM states, opcode classes, opcodes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LDI = 3'd1,
        CLS_MEM = 3'd2,
        CLS_BR  = 3'd3,
        CLS_JMP = 3'd4
    } cls_t;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: legality, class, ALU code, store flag.
// LDI routes its immediate through the ALU as an add.
module op_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int ALUOP_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                legal,
    output logic [2:0]          cls,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                is_store
);

    logic [2:0] lo;
    logic [3:0] code;

    assign lo = opcode[2:0];

    always_comb begin
        legal    = (opcode >> 3) == '0;
        cls      = CLS_ALU;
        code     = ALU_ADD;
        is_store = 1'b0;
        unique case (lo)
            OP_LDI: begin cls = CLS_LDI; code = ALU_ADD; end
            OP_ADD: begin cls = CLS_ALU; code = ALU_ADD; end
            OP_SUB: begin cls = CLS_ALU; code = ALU_SUB; end
            OP_AND: begin cls = CLS_ALU; code = ALU_AND; end
            OP_LW:  begin cls = CLS_MEM; code = ALU_ADD; end
            OP_SW: begin
                cls      = CLS_MEM;
                code     = ALU_ADD;
                is_store = 1'b1;
            end
            OP_BEQ: begin cls = CLS_BR;  code = ALU_SUB; end
            OP_JMP: begin cls = CLS_JMP; code = ALU_ADD; end
            default: ;
        endcase
        alu_op = ALUOP_W'(code);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a HALT trap
// for illegal opcodes and a req/ack handshake to shared memory.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int ALUOP_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_load,
    output logic                pc_write,
    output logic                jump_pc,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_write,
    output logic                imm_load,
    output logic                mem_to_reg,
    output logic                retire,
    output logic                illegal,
    output logic [2:0]          state_o
);

    state_t                state;
    logic [OPCODE_W-1:0]   op_q;
    logic                  dec_legal;
    logic [2:0]            dec_cls;
    logic [ALUOP_W-1:0]    dec_alu;
    logic                  dec_store;
    logic                  op_ok;

    op_decode #(
        .OPCODE_W(OPCODE_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .opcode  (op_q),
        .legal   (dec_legal),
        .cls     (dec_cls),
        .alu_op  (dec_alu),
        .is_store(dec_store)
    );

    // The branch to HALT is taken on the live opcode, before op_q settles.
    assign op_ok = (opcode >> 3) == '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (mem_ack) state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= op_ok ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    case (dec_cls)
                        CLS_MEM:         state <= S_MEM;
                        CLS_BR, CLS_JMP: state <= S_FETCH;
                        default:         state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack)
                        state <= dec_store ? S_FETCH : S_WB;
                end
                S_WB:   state <= S_FETCH;
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        jump_pc    = 1'b0;
        alu_op     = '0;
        reg_write  = 1'b0;
        imm_load   = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        state_o    = '0;
        if (rst) begin
            state_o = state;
            unique case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_load  = mem_ack;
                    pc_write = mem_ack;
                end
                S_DECODE: ;
                S_EXEC: begin
                    alu_op = dec_alu;
                    case (dec_cls)
                        CLS_BR: begin
                            pc_write = zero;
                            jump_pc  = zero;
                            retire   = 1'b1;
                        end
                        CLS_JMP: begin
                            pc_write = 1'b1;
                            jump_pc  = 1'b1;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = dec_store;
                    alu_op  = ALUOP_W'(ALU_ADD);
                    retire  = mem_ack && dec_store;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    imm_load   = dec_cls == CLS_LDI;
                    mem_to_reg = dec_cls == CLS_MEM;
                    retire     = 1'b1;
                end
                // op_q keeps the offending opcode, so the flag is sticky.
                S_HALT: illegal = !dec_legal;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected-trace model,
// negedge compare process, and literal latency/count pins.
module tb_multicycle_control;

    localparam int OW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ack = 1'b1;
    logic          mem_req, mem_we, ir_load, pc_write, jump_pc;
    logic [AW-1:0] alu_op;
    logic          reg_write, imm_load, mem_to_reg, retire, illegal;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    multicycle_control #(.OPCODE_W(OW), .ALUOP_W(AW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .ir_load(ir_load), .pc_write(pc_write), .jump_pc(jump_pc),
        .alu_op(alu_op), .reg_write(reg_write), .imm_load(imm_load),
        .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal),
        .state_o(state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, irl, pcw, jmp;
        logic [3:0] alu;
        logic       rw, imm, m2r, ret, ill;
    } ev_t;

    ev_t q[$];
    ev_t e_exp, e_act;
    int  checks = 0;
    int  failures = 0;
    int  lat_cnt = 0;
    int  last_lat = 0;
    int  retire_cnt = 0;
    int  rw_cnt = 0;
    int  n_legal = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Outputs are combinational; compare mid-cycle, one expectation per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_exp = q.pop_front();
            e_act = {state_o, mem_req, mem_we, ir_load, pc_write, jump_pc,
                     alu_op, reg_write, imm_load, mem_to_reg, retire,
                     illegal};
            chk("cycle", 32'(e_act), 32'(e_exp));
        end
        if (!rst) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (reg_write) rw_cnt++;
            if (retire) begin
                last_lat = lat_cnt;
                lat_cnt = 0;
                retire_cnt++;
            end
        end
    end

    function automatic logic [3:0] alu_of(input logic [2:0] o);
        case (o)
            3'd2, 3'd6: return 4'b0110;
            3'd3:       return 4'b0000;
            default:    return 4'b0010;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_in();
        opcode  = OW'($urandom);
        zero    = 1'($urandom);
        mem_ack = 1'($urandom);
    endtask

    task automatic do_reset(input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            tick();
            rand_in();
            rst = 1'b0;
            mem_ack = 1'b1;
            e = '0;
            q.push_back(e);
        end
    endtask

    task automatic halt_cycles(input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            tick();
            rst = 1'b1;
            rand_in();
            e = '0;
            e.st = 3'd5;
            e.ill = 1'b1;
            q.push_back(e);
        end
    endtask

    // fw/mw: memory wait cycles before ack; abort_at: MEM cycle to reset in.
    task automatic run_instr(input logic [OW-1:0] op, input int fw,
                             input int mw, input logic zv,
                             input int abort_at);
        ev_t e;
        logic [2:0] o;
        o = op[2:0];
        for (int i = 0; i <= fw; i++) begin
            tick();
            rst = 1'b1;
            rand_in();
            mem_ack = (i == fw);
            e = '0;
            e.req = 1'b1;
            e.irl = (i == fw);
            e.pcw = (i == fw);
            q.push_back(e);
        end
        tick();
        rand_in();
        opcode = op;
        e = '0;
        e.st = 3'd1;
        q.push_back(e);
        if ((op >> 3) != 0) return;
        tick();
        rand_in();
        zero = zv;
        e = '0;
        e.st = 3'd2;
        e.alu = alu_of(o);
        if (o == 3'd6) begin
            e.pcw = zv;
            e.jmp = zv;
            e.ret = 1'b1;
        end
        if (o == 3'd7) begin
            e.pcw = 1'b1;
            e.jmp = 1'b1;
            e.ret = 1'b1;
        end
        q.push_back(e);
        if (o >= 3'd6) begin
            n_legal++;
            return;
        end
        if (o == 3'd4 || o == 3'd5) begin
            for (int i = 0; i <= mw; i++) begin
                tick();
                rand_in();
                if (i == abort_at) begin
                    rst = 1'b0;
                    e = '0;
                    q.push_back(e);
                    return;
                end
                mem_ack = (i == mw);
                e = '0;
                e.st = 3'd3;
                e.req = 1'b1;
                e.we = (o == 3'd5);
                e.alu = 4'b0010;
                e.ret = (i == mw) && (o == 3'd5);
                q.push_back(e);
            end
            if (o == 3'd5) begin
                n_legal++;
                return;
            end
        end
        tick();
        rand_in();
        e = '0;
        e.st = 3'd4;
        e.rw = 1'b1;
        e.imm = (o == 3'd0);
        e.m2r = (o == 3'd4);
        e.ret = 1'b1;
        q.push_back(e);
        n_legal++;
    endtask

    int rc, wc;

    initial begin
        do_reset(2);
        settle();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_req", 32'(mem_req), 32'd0);

        run_instr(4'b0001, 2, 0, 1'b0, -1);
        settle();
        chk("lat_add_fw2", last_lat, 6);
        run_instr(4'b0000, 0, 0, 1'b0, -1);
        settle();
        chk("lat_ldi", last_lat, 4);
        run_instr(4'b0010, 0, 0, 1'b1, -1);
        settle();
        chk("lat_sub", last_lat, 4);
        run_instr(4'b0011, 0, 0, 1'b0, -1);
        settle();
        chk("lat_and", last_lat, 4);
        run_instr(4'b0100, 0, 3, 1'b0, -1);
        settle();
        chk("lat_lw_mw3", last_lat, 8);
        run_instr(4'b0101, 0, 0, 1'b0, -1);
        settle();
        chk("lat_sw", last_lat, 4);
        run_instr(4'b0101, 1, 2, 1'b0, -1);
        settle();
        chk("lat_sw_waits", last_lat, 7);
        run_instr(4'b0110, 0, 0, 1'b1, -1);
        settle();
        chk("lat_beq_taken", last_lat, 3);
        run_instr(4'b0110, 0, 0, 1'b0, -1);
        settle();
        chk("lat_beq_not", last_lat, 3);
        run_instr(4'b0111, 0, 0, 1'b0, -1);
        settle();
        chk("lat_jmp", last_lat, 3);

        for (int k = 0; k < 150; k++) begin
            run_instr(OW'($urandom_range(0, 7)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom), -1);
        end
        settle();
        chk("retire_count", retire_cnt, n_legal);

        rc = retire_cnt;
        wc = rw_cnt;
        run_instr(4'b0100, 0, 5, 1'b0, 2);
        settle();
        chk("abort_no_retire", retire_cnt, rc);
        chk("abort_no_regwr", rw_cnt, wc);
        run_instr(4'b0001, 0, 0, 1'b0, -1);
        settle();
        chk("lat_after_abort", last_lat, 4);

        run_instr(4'b1001, 0, 0, 1'b0, -1);
        halt_cycles(20);
        settle();
        chk("halt_illegal", 32'(illegal), 32'd1);
        chk("halt_no_req", 32'(mem_req), 32'd0);
        do_reset(1);
        settle();
        chk("halt_cleared", 32'(illegal), 32'd0);
        run_instr(4'b0011, 1, 0, 1'b0, -1);
        settle();
        chk("lat_after_halt", last_lat, 5);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
